program_run_controller: RTL

- Parametrised run/handshake controller in front of the single-cycle core.
- Accepts a four-phase req/ack request with a program select and launches the core at that program's start address.
- Detects completion when the core PC equals that program's done address, then reports a cycle count.
- Generalises the fixed single-done-address ack compare to NUM_PROGS programs with per-program start/done addresses, abort and cycle accounting.

---
 rtl/program_run_controller.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/program_run_controller.sv
// program_run_controller
// Run/handshake controller in front of the single-cycle core. A four-phase
// req/ack request selects one of NUM_PROGS programs; the core is launched at
// that program's start address and the run completes when the core PC hits the
// program's done address. RUN cycles are counted (saturating) in cycle_count.
//
// Handshake: req is a level. It is accepted only in IDLE. ack rises when the run
// completes and stays high while req stays high; dropping req returns the block
// to IDLE on the next edge (ack falls on that edge). Dropping req before
// completion aborts the run, and ack never asserts for that request.
//
// Optional feature: define PRC_WATCHDOG_EN to end a run that reaches
// TIMEOUT_CYCLES RUN cycles without a PC match (ack=1, timeout=1). A PC match on
// the same edge takes priority. Without the macro, timeout stays 0.
//
// o_dbg_state exposes the FSM state (0=IDLE, 1=LOAD, 2=RUN, 3=DONE).
module program_run_controller #(
  parameter int PC_BITS        = 10,
  parameter int NUM_PROGS      = 4,
  parameter int SEL_BITS       = $clog2(NUM_PROGS),
  parameter int CYC_BITS       = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          req,
  input  logic [SEL_BITS-1:0]           prog_sel,
  input  logic [NUM_PROGS*PC_BITS-1:0]  start_addr_flat,
  input  logic [NUM_PROGS*PC_BITS-1:0]  done_addr_flat,
  input  logic [PC_BITS-1:0]            pc,
  output logic                          core_start,
  output logic [PC_BITS-1:0]            core_start_addr,
  output logic                          core_run,
  output logic                          busy,
  output logic                          ack,
  output logic                          timeout,
  output logic [CYC_BITS-1:0]           cycle_count,
  output logic [1:0]                    o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [SEL_BITS:0] NUM_PROGS_EXT = (SEL_BITS+1)'(NUM_PROGS);

  state_t                r_state;
  state_t                w_next;
  logic [SEL_BITS-1:0]   r_sel;
  logic                  r_core_start;
  logic [PC_BITS-1:0]    r_start_addr;
  logic                  r_ack;
  logic                  r_timeout;
  logic [CYC_BITS-1:0]   r_cycle;

  logic [PC_BITS-1:0]    w_start [NUM_PROGS];
  logic [PC_BITS-1:0]    w_done  [NUM_PROGS];
  logic [SEL_BITS-1:0]   w_sel_clamped;
  logic                  w_accept;
  logic                  w_match;
  logic [CYC_BITS-1:0]   w_cnt_inc;
  logic                  w_wd_hit;
  logic                  w_to_timeout;

  // Unpack the flat address buses into per-program views.
  for (genvar g = 0; g < NUM_PROGS; g++) begin : g_unpack
    assign w_start[g] = start_addr_flat[g*PC_BITS +: PC_BITS];
    assign w_done[g]  = done_addr_flat[g*PC_BITS +: PC_BITS];
  end

  // Out-of-range selects fall back to program 0.
  assign w_sel_clamped = ({1'b0, prog_sel} < NUM_PROGS_EXT) ? prog_sel : '0;
  assign w_accept      = (r_state == S_IDLE) && req;
  assign w_match       = (pc == w_done[r_sel]);
  // Count saturates at all-ones instead of wrapping.
  assign w_cnt_inc     = (r_cycle == '1) ? r_cycle : r_cycle + 1'b1;

`ifdef PRC_WATCHDOG_EN
  // The limit is hit on the edge where the count reaches TIMEOUT_CYCLES.
  assign w_wd_hit = (32'(w_cnt_inc) >= 32'(TIMEOUT_CYCLES));
`else
  assign w_wd_hit = 1'b0;
`endif

  // Only a watchdog exit without a simultaneous PC match flags timeout.
  assign w_to_timeout = (r_state == S_RUN) && req && !w_match && w_wd_hit;

  // Next-state decode; abort (req low) wins over completion.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req) w_next = S_LOAD;
      S_LOAD: w_next = req ? S_RUN : S_IDLE;
      S_RUN: begin
        if (!req)                      w_next = S_IDLE;
        else if (w_match || w_wd_hit)  w_next = S_DONE;
      end
      S_DONE: if (!req) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Latch the program on accept and present its start address during LOAD.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sel        <= '0;
      r_start_addr <= '0;
      r_core_start <= 1'b0;
    end else begin
      r_core_start <= w_accept;
      if (w_accept) begin
        r_sel        <= w_sel_clamped;
        r_start_addr <= w_start[w_sel_clamped];
      end
    end
  end

  // Cycle accounting: cleared on accept, counts every RUN cycle, else holds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                r_cycle <= '0;
    else if (w_accept)           r_cycle <= '0;
    else if (r_state == S_RUN)   r_cycle <= w_cnt_inc;
  end

  // Completion flags: ack follows DONE; timeout is decided on entry to DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ack     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_ack <= (w_next == S_DONE);
      if (w_next != S_DONE)      r_timeout <= 1'b0;
      else if (r_state == S_RUN) r_timeout <= w_to_timeout;
    end
  end

  assign core_start      = r_core_start;
  assign core_start_addr = r_start_addr;
  assign core_run        = (r_state == S_RUN);
  assign busy            = (r_state == S_LOAD) || (r_state == S_RUN);
  assign ack             = r_ack;
  assign timeout         = r_timeout;
  assign cycle_count     = r_cycle;
  assign o_dbg_state     = r_state;

endmodule
